repeat_fifo: RTL

- Parametrised successor to the team's count-decrementing event queue.
- Each entry is a DATA_WIDTH word whose low COUNT_WIDTH bits are a repeat count. The entry stays at the head for that many dequeues, then retires.
- Adds the following over the previous generation:
  - configurable count field;
  - correct simultaneous enqueue/retire accounting;
  - zero-count handling;
  - explicit head drop;
  - occupancy level and almost-full output;
  - sticky overflow/underflow flags.
- Sits between the spike/event generator and the neuron-processing pipeline.

---
 rtl/repeat_fifo_pkg.sv | 30 +++
 rtl/repeat_fifo_if.sv | 39 +++
 rtl/repeat_fifo_ptr_ctrl.sv | 109 ++++++++++
 rtl/repeat_fifo.sv | 111 +++++++++++
 4 files changed

// File: rtl/repeat_fifo_pkg.sv
// repeat_fifo_pkg
//   Shared packing definitions for repeat-count event entries. The event
//   generator, the neuron pipeline and repeat_fifo all import this package.
//   That way every block agrees on where the repeat count lives inside a word.
//   Contents:
//     DEF_ADDR_LEN / DEF_DATA_WIDTH / DEF_COUNT_WIDTH : default geometry
//     COUNT_LSB                                       : count field position
//     count_field()                                   : count extraction helper
package repeat_fifo_pkg;

  localparam int DEF_ADDR_LEN    = 5;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_COUNT_WIDTH = 16;
  localparam int COUNT_LSB       = 0;

  // Widest entry the helper accepts; callers zero-extend into it.
  localparam int MAX_DATA_WIDTH  = 64;

  // Returns the repeat count of an entry, right-aligned and zero-extended.
  // Callers cast the result down to their own COUNT_WIDTH.
  function automatic logic [MAX_DATA_WIDTH-1:0] count_field(
    input logic [MAX_DATA_WIDTH-1:0] entry,
    input int unsigned               count_width
  );
    logic [MAX_DATA_WIDTH-1:0] mask;
    mask = (64'd1 << count_width) - 64'd1;
    return (entry >> COUNT_LSB) & mask;
  endfunction

endpackage

// File: rtl/repeat_fifo_if.sv
// repeat_fifo_if
//   Groups the repeat_fifo request and status signals into one bundle.
//   master : producer/consumer side. Drives enqueue, dequeue, drop and
//            data_in, and observes the status outputs.
//   slave  : the repeat_fifo itself.
//   Signals: enqueue, dequeue, drop, data_in[DATA_WIDTH], data_out[DATA_WIDTH],
//            last, full, empty, almost_full, level[ADDR_LEN+1], overflow,
//            underflow.
interface repeat_fifo_if
  import repeat_fifo_pkg::*;
#(
  parameter int ADDR_LEN   = DEF_ADDR_LEN,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  enqueue;
  logic                  dequeue;
  logic                  drop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  last;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_LEN:0]     level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output enqueue, dequeue, drop, data_in,
    input  data_out, last, full, empty, almost_full, level, overflow, underflow
  );

  modport slave (
    input  enqueue, dequeue, drop, data_in,
    output data_out, last, full, empty, almost_full, level, overflow, underflow
  );

endinterface

// File: rtl/repeat_fifo_ptr_ctrl.sv
// fifo_ptr_ctrl
//   Pointer and occupancy bookkeeping for repeat_fifo.
//   This block decides whether a request is accepted or retires an entry.
//   It also keeps the sticky error flags.
//   Inputs : clk, reset (sync, active-high), enqueue, dequeue, drop,
//            head_last (head remaining count <= 1)
//   Outputs: head_ptr, tail_ptr, level, full, empty, almost_full,
//            overflow, underflow,
//            accept (write data_in at tail_ptr),
//            decrement (rewrite head entry with count-1)
module fifo_ptr_ctrl #(
  parameter int ADDR_LEN = 5,
  parameter int MAX_SIZE = 1 << ADDR_LEN,
  parameter int AF_LEVEL = MAX_SIZE - 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enqueue,
  input  logic              dequeue,
  input  logic              drop,
  input  logic              head_last,
  output logic [ADDR_LEN-1:0] head_ptr,
  output logic [ADDR_LEN-1:0] tail_ptr,
  output logic [ADDR_LEN:0] level,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow,
  output logic              accept,
  output logic              decrement
);

  localparam int LW = ADDR_LEN + 1;
  localparam logic [LW-1:0] MAX_LEVEL = LW'(MAX_SIZE);
  localparam logic [LW-1:0] AF_THRESH = LW'(AF_LEVEL);

  logic [ADDR_LEN-1:0] head_q, head_d;
  logic [ADDR_LEN-1:0] tail_q, tail_d;
  logic [LW-1:0]       level_q, level_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                retire_s;
  logic                pop_ok_s;

  // Status decode, request qualification and next-state computation.
  always_comb begin
    full        = (level_q == MAX_LEVEL);
    empty       = (level_q == {LW{1'b0}});
    almost_full = (level_q >= AF_THRESH);

    // Full is judged on the pre-edge level, so a same-cycle retire never
    // makes room for the incoming entry.
    accept   = enqueue & ~full;
    pop_ok_s = ~empty;

    // Drop outranks dequeue. A dequeue retires only on the final repeat.
    if (pop_ok_s && drop) begin
      retire_s = 1'b1;
    end else if (pop_ok_s && dequeue && head_last) begin
      retire_s = 1'b1;
    end else begin
      retire_s = 1'b0;
    end

    decrement = pop_ok_s & dequeue & ~drop;

    if (retire_s) begin
      head_d = head_q + ADDR_LEN'(1);
    end else begin
      head_d = head_q;
    end

    if (accept) begin
      tail_d = tail_q + ADDR_LEN'(1);
    end else begin
      tail_d = tail_q;
    end

    // Both terms apply together, so accept+retire in one cycle nets to zero.
    level_d     = level_q + LW'(accept) - LW'(retire_s);
    overflow_d  = overflow_q | (enqueue & full);
    underflow_d = underflow_q | ((dequeue | drop) & empty);

    head_ptr  = head_q;
    tail_ptr  = tail_q;
    level     = level_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

  // Pointer, level and sticky flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= {ADDR_LEN{1'b0}};
      tail_q      <= {ADDR_LEN{1'b0}};
      level_q     <= {LW{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: rtl/repeat_fifo.sv
// repeat_fifo
//   Event queue in which each entry is delivered a number of times before it
//   retires. The number of deliveries is the entry's low COUNT_WIDTH bits.
//   A zero count is stored as 1. drop retires the head immediately.
//   Ports: clk, reset (sync, active-high), bus (repeat_fifo_if.slave)
//     bus.data_out    : head entry with its remaining count (0 when empty)
//     bus.last        : the next dequeue retires the head
//     bus.level       : occupancy; full/empty/almost_full decode it
//     bus.overflow    : sticky flag, set by an enqueue while full
//     bus.underflow   : sticky flag, set by a dequeue or drop while empty
module repeat_fifo
  import repeat_fifo_pkg::*;
#(
  parameter int ADDR_LEN    = DEF_ADDR_LEN,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int MAX_SIZE    = 1 << ADDR_LEN,
  parameter int AF_LEVEL    = MAX_SIZE - 4
) (
  input  logic          clk,
  input  logic          reset,
  repeat_fifo_if.slave  bus
);

  logic [DATA_WIDTH-1:0]  mem_q [MAX_SIZE];

  logic [ADDR_LEN-1:0]    head_ptr_s;
  logic [ADDR_LEN-1:0]    tail_ptr_s;
  logic                   accept_s;
  logic                   decrement_s;
  logic                   empty_s;
  logic                   head_last_s;
  logic [DATA_WIDTH-1:0]  head_entry_s;
  logic [COUNT_WIDTH-1:0] head_count_s;
  logic [COUNT_WIDTH-1:0] in_count_s;
  logic                   wr_en_d;
  logic [DATA_WIDTH-1:0]  wr_data_d;
  logic                   dec_en_d;
  logic [DATA_WIDTH-1:0]  dec_data_d;

  fifo_ptr_ctrl #(
    .ADDR_LEN (ADDR_LEN),
    .MAX_SIZE (MAX_SIZE),
    .AF_LEVEL (AF_LEVEL)
  ) u_ptr_ctrl (
    .clk         (clk),
    .reset       (reset),
    .enqueue     (bus.enqueue),
    .dequeue     (bus.dequeue),
    .drop        (bus.drop),
    .head_last   (head_last_s),
    .head_ptr    (head_ptr_s),
    .tail_ptr    (tail_ptr_s),
    .level       (bus.level),
    .full        (bus.full),
    .empty       (empty_s),
    .almost_full (bus.almost_full),
    .overflow    (bus.overflow),
    .underflow   (bus.underflow),
    .accept      (accept_s),
    .decrement   (decrement_s)
  );

  // Head view, stored-entry normalisation and count decrement.
  always_comb begin
    head_entry_s = mem_q[head_ptr_s];
    head_count_s = COUNT_WIDTH'(count_field(MAX_DATA_WIDTH'(head_entry_s), COUNT_WIDTH));
    in_count_s   = COUNT_WIDTH'(count_field(MAX_DATA_WIDTH'(bus.data_in), COUNT_WIDTH));

    // Stale memory is hidden while empty.
    if (empty_s) begin
      bus.data_out = {DATA_WIDTH{1'b0}};
      head_last_s  = 1'b0;
    end else begin
      bus.data_out = head_entry_s;
      head_last_s  = (head_count_s <= COUNT_WIDTH'(1));
    end
    bus.last  = head_last_s;
    bus.empty = empty_s;

    // A zero count would never be delivered, so it is promoted to one.
    wr_data_d = bus.data_in;
    if (in_count_s == {COUNT_WIDTH{1'b0}}) begin
      wr_data_d[COUNT_WIDTH-1:0] = COUNT_WIDTH'(1);
    end else begin
      wr_data_d[COUNT_WIDTH-1:0] = in_count_s;
    end

    // The payload is kept and only the count field is rewritten. Writing
    // a retiring slot is harmless because that slot is free afterwards.
    dec_data_d                  = head_entry_s;
    dec_data_d[COUNT_WIDTH-1:0] = head_count_s - COUNT_WIDTH'(1);

    // Reset abandons any write requested in the same cycle.
    wr_en_d  = accept_s & ~reset;
    dec_en_d = decrement_s & ~reset;
  end

  // Storage array. There is no reset, so contents survive reset.
  // Head and tail writes never collide: head==tail only when the FIFO is
  // empty, which blocks the decrement, or full, which blocks the enqueue.
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem_q[tail_ptr_s] <= wr_data_d;
    end
    if (dec_en_d) begin
      mem_q[head_ptr_s] <= dec_data_d;
    end
  end

endmodule
